// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: packed command-record FIFO with IDLE/LAUNCH/BUSY launch sequencer.
// Optional BUSY watchdog is enabled by defining SPI_CMDQ_TIMEOUT_EN.
module spi_cmd_sequencer #(
  parameter int W = 32,
  parameter int NWORDS = 18,
  parameter int DEPTH = 16,
  parameter logic [NWORDS-1:0] NEED_MASK = 18'b111111110011111111,
  parameter int GO_WORD = 1,
  parameter int GO_BIT = 0,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push_valid,
  output logic                      push_ready,
  input  logic [NWORDS*W-1:0]       push_data,
  input  logic                      flush,
  input  logic                      ctrl_ready,
  output logic                      cmd_valid,
  output logic [NWORDS*W-1:0]       cmd_data,
  input  logic                      resp_done,
  output logic [$clog2(DEPTH):0]    level,
  output logic [15:0]               nop_cnt,
  output logic                      timeout_pulse,
  output logic                      busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = NWORDS * W;
  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY} state_t;
  state_t state, state_nx;
  logic [RW-1:0] mask;
  logic [RW-1:0] mem [DEPTH];
  logic [DEPTH-1:0] go_mem;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic go_l, push_ok, pop, to_hit;
  for (genvar k = 0; k < NWORDS; k++) begin : g_mask
    assign mask[k*W +: W] = {W{NEED_MASK[k]}};
  end
  assign push_ready = (level != (AW+1)'(DEPTH)) && !flush;
  assign push_ok = push_valid && push_ready;
  // flush beats a coincident launch: nothing is popped that cycle
  assign pop = (state == IDLE) && (level != '0) && ctrl_ready && !flush;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data & mask;
      go_mem[wr_ptr] <= push_data[GO_WORD*W + GO_BIT];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      cmd_data <= '0;
      go_l <= 1'b0;
      nop_cnt <= '0;
      state <= IDLE;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        level <= level + (AW+1)'(push_ok) - (AW+1)'(pop);
      end
      if (pop) begin
        cmd_data <= mem[rd_ptr];
        go_l <= go_mem[rd_ptr];
      end
      if (state == LAUNCH && !go_l && nop_cnt != 16'hFFFF) nop_cnt <= nop_cnt + 16'd1;
      state <= state_nx;
    end
  end
  always_comb begin
    state_nx = state;
    cmd_valid = 1'b0;
    case (state)
      IDLE:    state_nx = pop ? LAUNCH : IDLE;
      LAUNCH: begin
        cmd_valid = go_l;
        state_nx = go_l ? BUSY : IDLE;
      end
      BUSY:    state_nx = (resp_done || to_hit) ? IDLE : BUSY;
      default: state_nx = IDLE;
    endcase
  end
`ifdef SPI_CMDQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0] wd_cnt;
  // counter sits at 0 outside BUSY, so it is already cleared on BUSY entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_cnt <= '0;
    else wd_cnt <= (state == BUSY) ? wd_cnt + TW'(1) : '0;
  end
  assign to_hit = (state == BUSY) && (wd_cnt == TW'(TIMEOUT_CYC - 1));
  assign timeout_pulse = to_hit && !resp_done;
`else
  assign to_hit = 1'b0;
  assign timeout_pulse = 1'b0;
`endif
endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb_spi_cmd_sequencer: directed scenarios plus random traffic checked against a queue-based model.
module tb_spi_cmd_sequencer;
  localparam int W = 32;
  localparam int NWORDS = 18;
  localparam int DEPTH = 16;
  localparam int TIMEOUT_CYC = 8;
  localparam int GO_WORD = 1;
  localparam int GO_BIT = 0;
  localparam int RW = W * NWORDS;
  localparam logic [NWORDS-1:0] NEED_MASK = 18'b111111110011111111;
  logic clk, rst_n, push_valid, push_ready, flush, ctrl_ready, cmd_valid, resp_done, timeout_pulse, busy;
  logic [RW-1:0] push_data, cmd_data;
  logic [$clog2(DEPTH):0] level;
  logic [15:0] nop_cnt;
  int checks, errors, strobes, pulses;
  logic [RW-1:0] q [$];
  bit gq [$];
  bit pend, pend_go, waiting;
  int wcnt, nops;
  logic [RW-1:0] cur;

  spi_cmd_sequencer #(
    .W(W), .NWORDS(NWORDS), .DEPTH(DEPTH), .NEED_MASK(NEED_MASK),
    .GO_WORD(GO_WORD), .GO_BIT(GO_BIT), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .push_valid(push_valid), .push_ready(push_ready),
    .push_data(push_data), .flush(flush), .ctrl_ready(ctrl_ready), .cmd_valid(cmd_valid),
    .cmd_data(cmd_data), .resp_done(resp_done), .level(level), .nop_cnt(nop_cnt),
    .timeout_pulse(timeout_pulse), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] masked(input logic [RW-1:0] d);
    for (int k = 0; k < NWORDS; k++) if (!NEED_MASK[k]) d[k*W +: W] = '0;
    return d;
  endfunction

  function automatic logic [RW-1:0] rec(input bit go);
    logic [RW-1:0] d;
    for (int k = 0; k < NWORDS; k++) d[k*W +: W] = $urandom;
    d[GO_WORD*W + GO_BIT] = go;
    return d;
  endfunction

  task automatic model_clear();
    q.delete();
    gq.delete();
    pend = 0;
    pend_go = 0;
    waiting = 0;
    wcnt = 0;
    nops = 0;
    cur = '0;
  endtask

  task automatic step(input bit pv, input logic [RW-1:0] pd, input bit fl, input bit cr, input bit rd);
    bit e_ready, e_to, pop, acc;
    @(negedge clk);
    push_valid = pv;
    push_data = pd;
    flush = fl;
    ctrl_ready = cr;
    resp_done = rd;
    #1;
    e_ready = (q.size() < DEPTH) && !fl;
    e_to = 0;
`ifdef SPI_CMDQ_TIMEOUT_EN
    e_to = waiting && (wcnt == TIMEOUT_CYC - 1) && !rd;
`endif
    chk("push_ready", RW'(push_ready), RW'(e_ready));
    chk("level", RW'(level), RW'(q.size()));
    chk("cmd_valid", RW'(cmd_valid), RW'(pend && pend_go));
    chk("busy", RW'(busy), RW'(pend || waiting));
    chk("cmd_data", cmd_data, cur);
    chk("nop_cnt", RW'(nop_cnt), RW'(nops));
    chk("timeout_pulse", RW'(timeout_pulse), RW'(e_to));
    if (cmd_valid) strobes++;
    if (timeout_pulse) pulses++;
    pop = !pend && !waiting && q.size() != 0 && cr && !fl;
    acc = pv && e_ready;
    if (pend) begin
      if (pend_go) begin
        waiting = 1;
        wcnt = 0;
      end else if (nops < 65535) nops++;
      pend = 0;
    end else if (waiting) begin
      if (rd || e_to) waiting = 0;
      else wcnt++;
    end
    if (fl) begin
      q.delete();
      gq.delete();
    end else begin
      if (pop) begin
        cur = masked(q.pop_front());
        pend_go = gq.pop_front();
        pend = 1;
      end
      if (acc) begin
        q.push_back(pd);
        gq.push_back(pd[GO_WORD*W + GO_BIT]);
      end
    end
  endtask

  task automatic hard_reset();
    @(negedge clk);
    push_valid = 0;
    flush = 0;
    ctrl_ready = 0;
    resp_done = 0;
    #2;
    rst_n = 0;
    #1;
    chk("rst_push_ready", RW'(push_ready), RW'(1));
    chk("rst_cmd_valid", RW'(cmd_valid), '0);
    chk("rst_cmd_data", cmd_data, '0);
    chk("rst_level", RW'(level), '0);
    chk("rst_nop_cnt", RW'(nop_cnt), '0);
    chk("rst_timeout", RW'(timeout_pulse), '0);
    chk("rst_busy", RW'(busy), '0);
    model_clear();
    strobes = 0;
    pulses = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    logic [RW-1:0] d;
    checks = 0;
    errors = 0;
    rst_n = 0;
    push_valid = 0;
    push_data = '0;
    flush = 0;
    ctrl_ready = 0;
    resp_done = 0;
    model_clear();
    repeat (2) @(posedge clk);
    hard_reset();
    // single launch, latency N+2
    d = rec(1);
    d[W +: W] = 32'h1;
    d[3*W +: W] = 32'hA5A5_0000;
    step(1, d, 0, 1, 0);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 0);
    chk("single_valid", RW'(cmd_valid), RW'(1));
    chk("single_w3", RW'(cmd_data[3*W +: W]), RW'(32'hA5A5_0000));
    chk("single_w8", RW'(cmd_data[8*W +: W]), '0);
    chk("single_w9", RW'(cmd_data[9*W +: W]), '0);
    repeat (3) step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 1);
    repeat (2) step(0, '0, 0, 1, 0);
    // fill and overflow
    hard_reset();
    for (int i = 0; i < 17; i++) step(1, rec(1), 0, 0, 0);
    chk("fill_level", RW'(level), RW'(DEPTH));
    for (int i = 0; i < 60; i++) step(0, '0, 0, 1, 1);
    chk("fill_strobes", RW'(strobes), RW'(DEPTH));
    // NOP skip
    hard_reset();
    step(1, rec(0), 0, 1, 0);
    step(1, rec(1), 0, 1, 0);
    step(1, rec(0), 0, 1, 0);
    for (int i = 0; i < 10; i++) step(0, '0, 0, 1, i == 5);
    chk("nop_count", RW'(nop_cnt), RW'(2));
    chk("nop_strobes", RW'(strobes), RW'(1));
    // flush while BUSY
    hard_reset();
    for (int i = 0; i < 5; i++) step(1, rec(1), 0, 1, 0);
    repeat (2) step(0, '0, 0, 1, 0);
    step(0, '0, 1, 1, 0);
    repeat (3) step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 1);
    repeat (6) step(0, '0, 0, 1, 0);
    chk("flush_strobes", RW'(strobes), RW'(1));
    // watchdog expiry, then resp_done coinciding with expiry
    for (int run = 0; run < 2; run++) begin
      hard_reset();
      step(1, rec(1), 0, 1, 0);
      for (int i = 0; i < 14; i++) step(0, '0, 0, 1, run == 1 && waiting && wcnt == TIMEOUT_CYC - 1);
      step(0, '0, 0, 1, 1);
      repeat (2) step(0, '0, 0, 1, 0);
`ifdef SPI_CMDQ_TIMEOUT_EN
      chk("wd_pulses", RW'(pulses), RW'(run == 0));
`else
      chk("wd_pulses", RW'(pulses), '0);
`endif
    end
    // reset mid-BUSY with 3 records queued
    hard_reset();
    for (int i = 0; i < 4; i++) step(1, rec(1), 0, 1, 0);
    repeat (2) step(0, '0, 0, 1, 0);
    chk("pre_rst_busy", RW'(busy), RW'(1));
    hard_reset();
    step(0, '0, 0, 0, 0);
    chk("post_rst_level", RW'(level), '0);
    // random traffic
    hard_reset();
    for (int i = 0; i < 1500; i++)
      step($urandom_range(1, 0) == 1, rec($urandom_range(9, 0) < 7), $urandom_range(31, 0) == 0,
           $urandom_range(9, 0) < 7, $urandom_range(4, 0) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_cmd_sequencer.md
# spi_cmd_sequencer

Single-clock, parametrised command queue and launch sequencer between the register file and the AWMF SPI controller (`awstd_controller`). Whole command records (NWORDS × W bits) are pushed atomically into one packed FIFO. Records are launched one at a time only when the controller is idle, and each launch holds the queue until the response completes. It generalises the per-field FIFO plus WAIT/LAUNCH/BUSY arrangement with the following additions:
- configurable record width, depth and required-word mask;
- explicit push handshake and backpressure;
- flush;
- NOP accounting;
- optional response watchdog.

## Interface
Parameters:
- `W`, 32, word width.
- `NWORDS`, 18, words per command record.
- `DEPTH`, 16, FIFO depth in records; power of 2, ≥2.
- `NEED_MASK`, 18'b111111110011111111, words stored/forwarded; unmasked words are forced to 0 at `cmd_data`.
- `GO_WORD`, 1, word index holding the GO flag.
- `GO_BIT`, 0, bit index of the GO flag within `GO_WORD`.
- `TIMEOUT_CYC`, 4096, BUSY watchdog limit in clk cycles; ≥2.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  sequencer clock (SPI master clock domain).
- `rst_n`  in  1  asynchronous active-low reset.
- `push_valid`  in  1  record offered.
- `push_ready`  out  1  = !full && !flush.
- `push_data`  in  NWORDS*W  record; word k = bits [k*W +: W].
- `flush`  in  1  synchronous queue clear.
- `ctrl_ready`  in  1  controller idle (`cmd_ready`).
- `cmd_valid`  out  1  one-cycle launch strobe.
- `cmd_data`  out  NWORDS*W  latched record; stable from LAUNCH until the next LAUNCH.
- `resp_done`  in  1  controller transaction complete.
- `level`  out  $clog2(DEPTH)+1  records queued.
- `nop_cnt`  out  16  saturating count of records popped with GO=0.
- `timeout_pulse`  out  1  one-cycle watchdog expiry strobe.
- `busy`  out  1  state != IDLE.

## Operation
- **Push:** accepted when `push_valid && push_ready`. The record is written at the tail and `level` increments. Writes with `push_ready=0` are dropped and never stored. Only `NEED_MASK` words need storage.
- **FSM states:** IDLE, LAUNCH, BUSY.
- **IDLE → LAUNCH:** when `level != 0 && ctrl_ready`. On that edge the head record is latched into `cmd_data` (masked), the head is popped, and `go_l` ← `push`-time word `GO_WORD` bit `GO_BIT`.
- **LAUNCH with `go_l=1`:** `cmd_valid=1`; next state BUSY.
- **LAUNCH with `go_l=0`:** `cmd_valid=0`; `nop_cnt` increments, saturating at 16'hFFFF; next state IDLE. NOPs never stall the queue.
- **BUSY:** waits for `resp_done`, then goes to IDLE.
- **`resp_done` outside BUSY:** ignored.
- **Pointers:** wrap modulo DEPTH. Full is `level==DEPTH`; empty is `level==0`.
- **Push and pop in the same cycle:** `level` is unchanged and both operations take effect. A push into a FIFO that is full at the start of the cycle is never accepted, even if a pop occurs that cycle.
- **Flush:** sets pointers and `level` to 0 on the next edge and blocks any push in the same cycle. It does not abort LAUNCH or BUSY; the already-latched record completes normally. A flush in IDLE coincident with the launch condition wins: no pop and no launch.
- **Reset mid-operation:** all state is cleared immediately and queued records are lost.

## Timing
- **Reset values:** `push_ready=1`, `cmd_valid=0`, `cmd_data=0`, `level=0`, `nop_cnt=0`, `timeout_pulse=0`, `busy=0`; FSM in IDLE.
- **Launch latency:** push accepted at edge N with the FIFO empty and `ctrl_ready=1` → `cmd_valid` high during cycle N+2.
- **Back-to-back:** `resp_done` in cycle M with the queue non-empty → `cmd_valid` in cycle M+2. Sustained rate is one launch per transaction + 2 cycles.
- **`cmd_valid` width:** exactly one cycle per GO record; never asserted twice without an intervening BUSY → IDLE transition.
- **`level`:** registered; updates on the edge following push/pop.

## Configuration
- **`SPI_CMDQ_TIMEOUT_EN` defined:**
  - A counter clears on BUSY entry and increments every BUSY cycle.
  - On reaching `TIMEOUT_CYC-1` without `resp_done`: `timeout_pulse=1` for one cycle and the FSM goes to IDLE.
  - If `resp_done` and expiry fall in the same cycle, `resp_done` wins and there is no pulse.
- **Undefined:**
  - BUSY waits indefinitely.
  - `timeout_pulse` is tied to 0.
  - `TIMEOUT_CYC` is unused and no counter is synthesised.

## Test plan
- **Single launch:** reset, then push one record with word1=32'h1 and word3=32'hA5A5_0000, `ctrl_ready=1` → `cmd_valid` in cycle N+2. `cmd_data` word3=32'hA5A5_0000, words 8/9 = 0, `busy=1` until `resp_done`, then `busy=0`.
- **Fill/overflow:** push DEPTH=16 records with `ctrl_ready=0` → `level=16` and `push_ready=0`. A 17th push is dropped. After 16 resp_done cycles, exactly 16 `cmd_valid` strobes occur, in FIFO order.
- **NOP skip:** push records with GO=0, GO=1, GO=0 → exactly one `cmd_valid` (the second record) and `nop_cnt=2`. The queue drains without waiting on `resp_done` for the NOPs.
- **Flush:** queue 5 records, first launched into BUSY, assert flush one cycle → `level=0` next cycle. The BUSY record completes on `resp_done` and no further `cmd_valid` occurs.
- **Watchdog (`SPI_CMDQ_TIMEOUT_EN`, `TIMEOUT_CYC=8`):** launch a GO record with `resp_done` held 0 → `timeout_pulse` on the 8th BUSY cycle, then the FSM returns to IDLE. A repeat run with `resp_done` in that same cycle gives no pulse.
- **Reset mid-BUSY:** assert `rst_n=0` with 3 records queued → all outputs take their reset values asynchronously, and `level=0` after release.
